sd_init_gate: RTL and testbench

Parametrised SD-card initialisation gate sequencer running in the CLOCK_50 domain. It synchronises the slow SD clock, counts its rising edges through the power-up dummy-clock window, then holds `gate_signal` asserted until the masked card response matches an expected value on enough consecutive SD clock edges, or until an edge-count timeout expires. It sits between the SD clock generator / response shifter and the command-path enable logic, and reports completion, error and progress to the top level.

---
 rtl/sd_init_gate.sv | 133 +++++++++++++
 tb/tb_sd_init_gate.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sd_init_gate.sv
// ============================================================================
// Module   : sd_init_gate
// Brief    : Gates the SD command path through the power-up dummy-clock window
//            and until the card response matches or an edge timeout expires.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_init_gate #(
    parameter int                CNT_W         = 16,
    parameter int                INIT_EDGES    = 363,
    parameter int                RESP_W        = 16,
    parameter logic [RESP_W-1:0] RESP_MASK     = 16'h00FF,
    parameter logic [RESP_W-1:0] RESP_EXPECT   = 16'h0000,
    parameter int                MATCH_EDGES   = 1,
    parameter int                TIMEOUT_EDGES = 4096
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              sd_clk_in,
    input  logic              start,
    input  logic [RESP_W-1:0] response_signal,
    output logic              gate_signal,
    output logic              done,
    output logic              timeout_err,
    output logic              busy,
    output logic [CNT_W-1:0]  edge_count
);

    localparam int c_TO_W = (TIMEOUT_EDGES < 2) ? 1 : $clog2(TIMEOUT_EDGES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_EDGES = 3'd1,
        S_WAIT_RESP  = 3'd2,
        S_DONE       = 3'd3,
        S_TIMEOUT    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_s1, r_s2, r_s3;
    logic                w_rise;
    logic [CNT_W-1:0]    r_edge_count, w_edge_nxt, w_edge_inc;
    logic [3:0]          r_match_cnt, w_match_nxt, w_match_inc;
    logic [c_TO_W-1:0]   r_to_cnt, w_to_nxt, w_to_inc;
    logic                w_resp_ok;
    logic                r_busy, r_done, r_timeout, r_gate;
    logic                w_busy_nxt;

    assign w_rise      = r_s2 & ~r_s3;
    assign w_resp_ok   = (response_signal & RESP_MASK) == RESP_EXPECT;
    assign w_edge_inc  = r_edge_count + CNT_W'(1);
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_to_inc    = r_to_cnt + c_TO_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = r_edge_count;
        w_match_nxt = r_match_cnt;
        w_to_nxt    = r_to_cnt;
        case (r_state)
            // Rises that coincide with start are deliberately dropped here.
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    w_state_nxt = S_WAIT_EDGES;
                    w_edge_nxt  = '0;
                    w_match_nxt = '0;
                    w_to_nxt    = '0;
                end
            end
            S_WAIT_EDGES: begin
                if (w_rise) begin
                    w_edge_nxt = w_edge_inc;
                    if (w_edge_inc == CNT_W'(INIT_EDGES))
                        w_state_nxt = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (w_rise) begin
                    w_edge_nxt  = (&r_edge_count) ? r_edge_count : w_edge_inc;
                    w_to_nxt    = w_to_inc;
                    w_match_nxt = w_resp_ok ? w_match_inc : 4'd0;
                    // A match completing on the timeout edge still reports DONE.
                    if (w_resp_ok && (w_match_inc == 4'(MATCH_EDGES)))
                        w_state_nxt = S_DONE;
                    else if ((TIMEOUT_EDGES != 0) && (w_to_inc == c_TO_W'(TIMEOUT_EDGES)))
                        w_state_nxt = S_TIMEOUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == S_WAIT_EDGES) || (w_state_nxt == S_WAIT_RESP);

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_state      <= S_IDLE;
            r_edge_count <= '0;
            r_match_cnt  <= '0;
            r_to_cnt     <= '0;
            r_busy       <= 1'b0;
            r_gate       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_s1         <= sd_clk_in;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_state      <= w_state_nxt;
            r_edge_count <= w_edge_nxt;
            r_match_cnt  <= w_match_nxt;
            r_to_cnt     <= w_to_nxt;
            r_busy       <= w_busy_nxt;
            r_gate       <= w_busy_nxt;
            r_done       <= (w_state_nxt == S_DONE);
            r_timeout    <= (w_state_nxt == S_TIMEOUT);
        end
    end

    assign gate_signal = r_gate;
    assign done        = r_done;
    assign timeout_err = r_timeout;
    assign busy        = r_busy;
    assign edge_count  = r_edge_count;

endmodule

`default_nettype wire

// File: tb/tb_sd_init_gate.sv
// ============================================================================
// Module   : tb_sd_init_gate
// Brief    : Directed scoreboard bench for sd_init_gate (INIT=8, MATCH=2, TO=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd_init_gate;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_clk_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] response_signal = 16'h0000;
    logic        gate_signal, done, timeout_err, busy;
    logic [15:0] edge_count;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] last_exp = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    sd_init_gate #(
        .CNT_W(16), .INIT_EDGES(8), .RESP_W(16), .RESP_MASK(16'h00FF),
        .RESP_EXPECT(16'h0000), .MATCH_EDGES(2), .TIMEOUT_EDGES(16)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n), .sd_clk_in(sd_clk_in), .start(start),
        .response_signal(response_signal), .gate_signal(gate_signal), .done(done),
        .timeout_err(timeout_err), .busy(busy), .edge_count(edge_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [19:0] mk(input logic g, input logic b, input logic d,
                                       input logic t, input int cnt);
        return {g, b, d, t, 16'(cnt)};
    endfunction

    task automatic push_exp(input string tag, input logic [19:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic [19:0] exp);
        logic [19:0] obs;
        obs = {gate_signal, busy, done, timeout_err, edge_count};
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed={gate,busy,done,to,cnt}=%h expected=%h", tag, obs, exp);
        end
        last_exp = exp;
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            check_now(e.tag, e.v);
        end
    endtask

    // One SD clock period (20 CLOCK_50 cycles); outputs must not move until
    // the third CLOCK_50 edge after sd_clk_in rises.
    task automatic sd_cycle(input logic [15:0] resp);
        @(negedge CLOCK_50);
        response_signal = resp;
        sd_clk_in = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_now("pre_update", last_exp);
        @(posedge CLOCK_50);
        #1;
        check_pop();
        repeat (7) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        sd_clk_in = 1'b0;
        repeat (10) @(posedge CLOCK_50);
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        check_pop();
    endtask

    initial begin
        // Reset with start high and the SD clock toggling.
        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            sd_clk_in = ~sd_clk_in;
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        sd_clk_in = 1'b0;
        #1;
        check_now("reset_hold", mk(0, 0, 0, 0, 0));
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (4) @(posedge CLOCK_50);
        #1;
        check_now("idle_after_reset", mk(0, 0, 0, 0, 0));

        // Nominal: 0x1200 masks to 0x00, so rises 9 and 10 complete.
        push_exp("nom_start", mk(1, 1, 0, 0, 0));
        pulse_start();
        for (int i = 1; i <= 10; i++) begin
            push_exp("nom_rise", (i == 10) ? mk(0, 0, 1, 0, 10) : mk(1, 1, 0, 0, i));
            sd_cycle(16'h1200);
            if (i == 3) begin
                push_exp("start_ignored_busy", mk(1, 1, 0, 0, 3));
                pulse_start();
            end
        end
        push_exp("done_frozen", mk(0, 0, 1, 0, 10));
        sd_cycle(16'h1200);

        // Match reset; matching data during the window must not pre-load the count.
        push_exp("mr_restart_from_done", mk(1, 1, 0, 0, 0));
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            push_exp("mr_window", mk(1, 1, 0, 0, i));
            sd_cycle(16'h0000);
        end
        push_exp("mr_r9", mk(1, 1, 0, 0, 9));
        sd_cycle(16'h0000);
        push_exp("mr_r10", mk(1, 1, 0, 0, 10));
        sd_cycle(16'h0001);
        push_exp("mr_r11", mk(1, 1, 0, 0, 11));
        sd_cycle(16'h0000);
        push_exp("mr_r12_done", mk(0, 0, 1, 0, 12));
        sd_cycle(16'h0000);

        // Timeout after 16 non-matching WAIT_RESP rises.
        push_exp("to_restart", mk(1, 1, 0, 0, 0));
        pulse_start();
        for (int i = 1; i <= 24; i++) begin
            push_exp("to_rise", (i == 24) ? mk(0, 0, 0, 1, 24) : mk(1, 1, 0, 0, i));
            sd_cycle(16'h00FF);
        end
        push_exp("timeout_frozen", mk(0, 0, 0, 1, 24));
        sd_cycle(16'h00FF);
        push_exp("restart_from_timeout", mk(1, 1, 0, 0, 0));
        pulse_start();

        // Mid-run reset at edge_count 5.
        for (int i = 1; i <= 5; i++) begin
            push_exp("mid_rise", mk(1, 1, 0, 0, i));
            sd_cycle(16'h00FF);
        end
        @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        check_now("mid_reset", mk(0, 0, 0, 0, 0));
        repeat (3) @(posedge CLOCK_50);
        push_exp("post_reset_start", mk(1, 1, 0, 0, 0));
        pulse_start();
        for (int i = 1; i <= 2; i++) begin
            push_exp("post_reset_rise", mk(1, 1, 0, 0, i));
            sd_cycle(16'h00FF);
        end

        n_assert++;
        assert (exp_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
